// File: rtl/cnn_buffer_pkg.sv
// Shared constants and types for the CNN buffer RAM array (read and write sides).
package cnn_buffer_pkg;

  localparam int ADDR_WIDTH = 14;
  localparam int ARRAY_SIZE = 9;
  localparam int DATA_SIZE  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/lane_skew_delay.sv
// Fixed-depth register chain carrying one lane word and its valid flag.
module lane_skew_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < DEPTH; s++) begin
        data_q[s] <= '0;
      end
      valid_q <= '0;
    end else begin
      data_q[0]  <= data_i;
      valid_q[0] <= valid_i;
      for (int s = 1; s < DEPTH; s++) begin
        data_q[s]  <= data_q[s-1];
        valid_q[s] <= valid_q[s-1];
      end
    end
  end

  assign data_o  = data_q[DEPTH-1];
  assign valid_o = valid_q[DEPTH-1];

endmodule

// File: rtl/buffer_skew_reader.sv
// Read sequencer for the buffer RAM banks: issues consecutive row addresses,
// realigns bank data after the RAM latency and skews lane i by i cycles.
module buffer_skew_reader
  import cnn_buffer_pkg::*;
#(
  parameter int array_size   = ARRAY_SIZE,
  parameter int data_size    = DATA_SIZE,
  parameter int addr_width   = ADDR_WIDTH,
  parameter int read_latency = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [addr_width-1:0]            base_addr,
  input  logic [addr_width:0]              length,
  output logic [addr_width-1:0]            addrb,
  input  logic [array_size*data_size-1:0]  bus2,
  output logic [array_size*data_size-1:0]  feed_data,
  output logic [array_size-1:0]            feed_valid,
  output logic                             busy,
  output logic                             done,
  output rd_state_e                        state_o
);

  // DRAIN covers the latency pipe plus the deepest skew chain.
  localparam int DRAIN_CYCLES = read_latency + array_size;
  localparam int DRAIN_W      = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

  rd_state_e                state_q;
  logic [addr_width-1:0]    base_q;
  logic [addr_width-1:0]    addrb_q;
  logic [addr_width-1:0]    addr_d;
  logic [addr_width:0]      len_q;
  logic [addr_width:0]      k_q;
  logic [DRAIN_W-1:0]       drain_q;
  logic                     issue_q;
  logic                     busy_q;
  logic                     done_q;
  logic [read_latency-1:0]  lat_q;
  logic                     aligned_valid;

  assign addr_d = base_q + k_q[addr_width-1:0];

  // busy_q stays high in the done cycle, so a start there is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      addrb_q <= '0;
      len_q   <= '0;
      k_q     <= '0;
      drain_q <= '0;
      issue_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          issue_q <= 1'b0;
          if (busy_q) begin
            busy_q <= 1'b0;
          end else if (start) begin
            busy_q <= 1'b1;
            if (length == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= READ;
              base_q  <= base_addr;
              len_q   <= length;
              addrb_q <= base_addr;
              k_q     <= {{addr_width{1'b0}}, 1'b1};
              issue_q <= 1'b1;
            end
          end
        end
        READ: begin
          if (k_q == len_q) begin
            state_q <= DRAIN;
            issue_q <= 1'b0;
            drain_q <= DRAIN_LOAD;
          end else begin
            addrb_q <= addr_d;
            k_q     <= k_q + 1'b1;
            issue_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (drain_q == '0) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_q <= '0;
    end else begin
      lat_q[0] <= issue_q;
      for (int s = 1; s < read_latency; s++) begin
        lat_q[s] <= lat_q[s-1];
      end
    end
  end

  assign aligned_valid = lat_q[read_latency-1];

  for (genvar i = 0; i < array_size; i++) begin : g_lane
    logic [data_size-1:0] lane_data;
    logic                 lane_valid;

    lane_skew_delay #(
      .DEPTH(i + 1),
      .WIDTH(data_size)
    ) u_skew (
      .clk     (clk),
      .rst_n   (rst_n),
      .data_i  (bus2[i*data_size +: data_size]),
      .valid_i (aligned_valid),
      .data_o  (lane_data),
      .valid_o (lane_valid)
    );

    assign feed_valid[i]                       = lane_valid;
    assign feed_data[i*data_size +: data_size] = lane_valid ? lane_data : '0;
  end

  assign addrb   = addrb_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign state_o = state_q;

endmodule
